// File: rtl/pixel_readout_ctrl.sv
// Pixel readout sequencer: erase, exposure with VBN1 strobes, single-slope ramp conversion, code delivery.
// Latency: ERASE_CYCLES + 2*EXPOSE_PULSES + k + 1 cycles from first erase cycle to data_valid (crossing code k).
// Backpressure: data/data_valid held in OUTPUT until data_ready; start ignored while busy (no queuing).
// Build option PIXEL_CDS_EN: adds a reset-level ramp (CONV_RST) after erase; data = signal - reset, floored at 0.

module pixel_readout_ctrl #(
   parameter int RESOLUTION    = 8,
   parameter int ERASE_CYCLES  = 5,
   parameter int EXPOSE_PULSES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  cmp,
   input  logic                  data_ready,
   output logic                  erase,
   output logic                  expose,
   output logic                  vbn1,
   output logic                  convert,
   output logic [RESOLUTION-1:0] ramp_code,
   output logic [RESOLUTION-1:0] data,
   output logic                  data_valid,
   output logic                  busy
);

   // One phase counter serves both ERASE and EXPOSE; size it for the longer of the two.
   localparam int CNT_SPAN = (2 * EXPOSE_PULSES > ERASE_CYCLES) ? 2 * EXPOSE_PULSES : ERASE_CYCLES;
   localparam int CW       = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;

   localparam logic [CW-1:0]         ERASE_LAST  = CW'(ERASE_CYCLES - 1);
   localparam logic [CW-1:0]         EXPOSE_LAST = CW'(2 * EXPOSE_PULSES - 1);
   localparam logic [RESOLUTION-1:0] MAX_CODE    = {RESOLUTION{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
`ifdef PIXEL_CDS_EN
      S_CONV_RST,
`endif
      S_EXPOSE,
      S_CONVERT,
      S_OUTPUT
   } state_t;

   state_t                  state, state_n;
   logic [CW-1:0]           cnt, cnt_n;
   logic [RESOLUTION-1:0]   ramp_n;
   logic [RESOLUTION-1:0]   data_n;
   logic                    ramp_phase_n;
   logic                    ramp_done;

`ifdef PIXEL_CDS_EN
   logic [RESOLUTION-1:0]   rst_code, rst_code_n;
`endif

   // Ramp stops on the first comparator hit, or at full scale so the code never wraps.
   assign ramp_done = cmp || (ramp_code == MAX_CODE);

   // State and phase-counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Next-state, counter, ramp and result computation.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ramp_n  = '0;
      data_n  = data;
`ifdef PIXEL_CDS_EN
      rst_code_n = rst_code;
`endif
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_ERASE;
               cnt_n   = '0;
            end
         end
         S_ERASE: begin
            if (cnt == ERASE_LAST) begin
`ifdef PIXEL_CDS_EN
               state_n = S_CONV_RST;
`else
               state_n = S_EXPOSE;
`endif
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
`ifdef PIXEL_CDS_EN
         S_CONV_RST: begin
            if (ramp_done) begin
               rst_code_n = ramp_code;
               state_n    = S_EXPOSE;
               cnt_n      = '0;
            end else begin
               ramp_n = ramp_code + 1'b1;
            end
         end
`endif
         S_EXPOSE: begin
            if (cnt == EXPOSE_LAST) begin
               state_n = S_CONVERT;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_CONVERT: begin
            if (ramp_done) begin
`ifdef PIXEL_CDS_EN
               data_n = (ramp_code >= rst_code) ? (ramp_code - rst_code) : '0;
`else
               data_n = ramp_code;
`endif
               state_n = S_OUTPUT;
            end else begin
               ramp_n = ramp_code + 1'b1;
            end
         end
         S_OUTPUT: begin
            if (data_valid && data_ready) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // The ramp/comparator runs in the signal conversion and, with CDS, the reset conversion.
   always_comb begin
      ramp_phase_n = (state_n == S_CONVERT);
`ifdef PIXEL_CDS_EN
      if (state_n == S_CONV_RST) begin
         ramp_phase_n = 1'b1;
      end
`endif
   end

   // Outputs registered from the next state so each pin lines up with the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         erase      <= 1'b0;
         expose     <= 1'b0;
         vbn1       <= 1'b0;
         convert    <= 1'b0;
         ramp_code  <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         erase      <= (state_n == S_ERASE);
         expose     <= (state_n == S_EXPOSE);
         vbn1       <= (state_n == S_EXPOSE) && cnt_n[0];
         convert    <= ramp_phase_n;
         ramp_code  <= ramp_n;
         data       <= data_n;
         data_valid <= (state_n == S_OUTPUT);
         busy       <= (state_n != S_IDLE);
      end
   end

`ifdef PIXEL_CDS_EN
   // Reset-level code captured at the end of CONV_RST, subtracted from the signal code.
   always_ff @(posedge clk) begin
      if (reset) begin
         rst_code <= '0;
      end else begin
         rst_code <= rst_code_n;
      end
   end
`endif

   // Pixel drives must never overlap.
   always @(posedge clk) begin
      if (!reset) begin
         assert ($onehot0({erase, expose, convert}));
      end
   end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
module tb_pixel_readout_ctrl;

   localparam int RES = 8;
   localparam int EC  = 4;
   localparam int EP  = 10;
`ifdef PIXEL_CDS_EN
   localparam int X0 = 1;   // extra cycle from a reset ramp that crosses at code 0
`else
   localparam int X0 = 0;
`endif

   logic           clk;
   logic           reset;
   logic           start;
   logic           cmp;
   logic           data_ready;
   logic           erase;
   logic           expose;
   logic           vbn1;
   logic           convert;
   logic [RES-1:0] ramp_code;
   logic [RES-1:0] data;
   logic           data_valid;
   logic           busy;

   int errors = 0;
   int checks = 0;
   int sb[$];

   // Comparator model: crossing threshold differs for the reset ramp and the signal ramp.
   int   thr_rst = 0;
   int   thr_sig = 0;
   logic seen_exp = 1'b0;

   pixel_readout_ctrl #(
      .RESOLUTION   (RES),
      .ERASE_CYCLES (EC),
      .EXPOSE_PULSES(EP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cmp       (cmp),
      .data_ready(data_ready),
      .erase     (erase),
      .expose    (expose),
      .vbn1      (vbn1),
      .convert   (convert),
      .ramp_code (ramp_code),
      .data      (data),
      .data_valid(data_valid),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (erase) seen_exp <= 1'b0;
      else if (expose) seen_exp <= 1'b1;
   end

   assign cmp = convert && (int'(ramp_code) >= (seen_exp ? thr_sig : thr_rst));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: samples just before each rising edge, pops on every handshake.
   initial begin : monitor
      int exp;
      forever begin
         @(negedge clk);
         #4;
         if (data_valid && data_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got data=%0d, required no output", data);
            end else begin
               exp = sb.pop_front();
               chk("sb_data", int'(data), exp);
            end
         end
      end
   end

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_idle"}, int'(busy), 0);
   endtask

   // One full conversion; returns at the first cycle data_valid is seen.
   task automatic do_run(input string nm, input int tr, input int ts,
                         input int exp_d, input int exp_lat, input int exp_max);
      int   t = 0, t_erase = -1, n_erase = 0, n_expose = 0, n_rise = 0;
      int   n_bad = 0, n_step = 0, max_ramp = 0, pramp = 0;
      logic pv = 1'b0, pconv = 1'b0;
      thr_rst = tr;
      thr_sig = ts;
      sb.push_back(exp_d);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!data_valid && t < 2000) begin
         if (erase && t_erase < 0) t_erase = t;
         if (erase) n_erase++;
         if (expose) n_expose++;
         if (vbn1 && !pv) begin
            n_rise++;
            if (!expose) n_bad++;
         end
         if (vbn1 && !expose) n_bad++;
         if ((int'(erase) + int'(expose) + int'(convert)) > 1) n_bad++;
         if (convert) begin
            if (int'(ramp_code) > max_ramp) max_ramp = int'(ramp_code);
            if (pconv && int'(ramp_code) != pramp + 1) n_step++;
            if (!pconv && ramp_code != 0) n_step++;
         end
         pv    = vbn1;
         pconv = convert;
         pramp = int'(ramp_code);
         @(negedge clk);
         t++;
      end
      chk({nm, "_valid_seen"}, int'(data_valid), 1);
      chk({nm, "_erase_cycles"}, n_erase, EC);
      chk({nm, "_expose_cycles"}, n_expose, 2 * EP);
      chk({nm, "_vbn1_rises"}, n_rise, EP);
      chk({nm, "_exclusive"}, n_bad, 0);
      chk({nm, "_ramp_steps"}, n_step, 0);
      chk({nm, "_ramp_max"}, max_ramp, exp_max);
      chk({nm, "_latency"}, t - t_erase, exp_lat);
      chk({nm, "_ramp_idle"}, int'(ramp_code), 0);
   endtask

   initial begin : stim
      int n, t, bad_dv, bad_d, bad_b;
      reset      = 1'b1;
      start      = 1'b0;
      data_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_erase", int'(erase), 0);
      chk("rst_expose", int'(expose), 0);
      chk("rst_vbn1", int'(vbn1), 0);
      chk("rst_convert", int'(convert), 0);
      chk("rst_ramp", int'(ramp_code), 0);
      chk("rst_data", int'(data), 0);
      chk("rst_valid", int'(data_valid), 0);
      chk("rst_busy", int'(busy), 0);
      reset = 1'b0;
      @(negedge clk);

      // Nominal crossing, full-scale saturation, immediate crossing, crossing exactly at MAX.
      do_run("t1", 0, 100, 100, EC + 2 * EP + 101 + X0, 100);
      wait_idle("t1");
      do_run("t2_sat", 0, 300, 255, EC + 2 * EP + 256 + X0, 255);
      wait_idle("t2_sat");
      do_run("t2_zero", 0, 0, 0, EC + 2 * EP + 1 + X0, 0);
      wait_idle("t2_zero");
      do_run("t2_max", 0, 255, 255, EC + 2 * EP + 256 + X0, 255);
      wait_idle("t2_max");

      // Backpressure in OUTPUT with a start pulse that must be ignored.
      data_ready = 1'b0;
      do_run("t3", 0, 77, 77, EC + 2 * EP + 78 + X0, 77);
      bad_dv = 0; bad_d = 0; bad_b = 0;
      for (int i = 0; i < 20; i++) begin
         start = (i == 5);
         @(negedge clk);
         if (!data_valid) bad_dv++;
         if (data != 8'd77) bad_d++;
         if (!busy) bad_b++;
      end
      start = 1'b0;
      chk("t3_hold_valid", bad_dv, 0);
      chk("t3_hold_data", bad_d, 0);
      chk("t3_hold_busy", bad_b, 0);
      data_ready = 1'b1;
      @(negedge clk);
      chk("t3_valid_drop", int'(data_valid), 0);
      chk("t3_busy_drop", int'(busy), 0);
      chk("t3_data_kept", int'(data), 77);
      repeat (5) @(negedge clk);
      chk("t3_start_ignored", int'(busy), 0);

      // Reset on the 7th exposure cycle.
      thr_rst = 0;
      thr_sig = 42;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      t = 0;
      while (t < 200) begin
         if (expose) n++;
         if (n == 7) break;
         @(negedge clk);
         t++;
      end
      chk("t4_reach7", n, 7);
      reset = 1'b1;
      @(negedge clk);
      chk("t4_expose", int'(expose), 0);
      chk("t4_vbn1", int'(vbn1), 0);
      chk("t4_busy", int'(busy), 0);
      chk("t4_drives", int'(erase) + int'(convert), 0);
      reset = 1'b0;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (data_valid || busy) n++;
      end
      chk("t4_no_output", n, 0);
      do_run("t4_fresh", 0, 42, 42, EC + 2 * EP + 43 + X0, 42);
      wait_idle("t4_fresh");

`ifdef PIXEL_CDS_EN
      // CDS: signal above reset subtracts; signal below reset floors at 0.
      do_run("t5_sub", 10, 100, 90, EC + 11 + 2 * EP + 101, 100);
      wait_idle("t5_sub");
      do_run("t5_floor", 50, 30, 0, EC + 51 + 2 * EP + 31, 50);
      wait_idle("t5_floor");
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pixel_readout_ctrl.md
Name: pixel_readout_ctrl

Overview:
Readout-side controller for one pixel sensor. It sequences erase and exposure, including the VBN1 integration strobes, then runs a single-slope conversion. The conversion drives a ramp DAC code and samples the analog comparator output. The resulting code is delivered on a valid/ready interface to the array readout logic.

Parameters:
RESOLUTION, 8, bits of ramp_code and data; full-scale code MAX = 2^RESOLUTION-1
ERASE_CYCLES, 5, clock cycles erase is held high (min 1)
EXPOSE_PULSES, 255, number of vbn1 rising edges issued during exposure (min 1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request one erase/expose/convert cycle; sampled only in IDLE
cmp  input  1  comparator output; 1 = ramp level has crossed pixel voltage for the current ramp_code
data_ready  input  1  downstream accepts data
erase  output  1  pixel ERASE drive
expose  output  1  pixel EXPOSE drive
vbn1  output  1  pixel VBN1 integration strobe
convert  output  1  ramp/comparator enable
ramp_code  output  RESOLUTION  ramp DAC code
data  output  RESOLUTION  converted pixel code
data_valid  output  1  data holds a valid code
busy  output  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset value of every output is 0. State after reset is IDLE.
- Reset asserted in any state, mid-operation included: next cycle all outputs are 0 and the state is IDLE. Any pending data is discarded.
- IDLE:
  - start=1 moves to ERASE.
  - start is ignored in all other states (no queuing).
- ERASE:
  - erase=1 for exactly ERASE_CYCLES cycles, then moves to EXPOSE.
- EXPOSE:
  - expose=1 for exactly 2*EXPOSE_PULSES cycles.
  - vbn1=0 on the first EXPOSE cycle and toggles every cycle after that. This gives exactly EXPOSE_PULSES rising edges, all while expose=1.
  - vbn1 is 0 outside EXPOSE.
  - Then moves to CONVERT.
- CONVERT:
  - convert=1.
  - ramp_code=0 on the first CONVERT cycle and increments by 1 each cycle.
  - cmp is sampled every CONVERT cycle and is taken to correspond to the ramp_code presented in that same cycle.
  - First cycle with cmp=1: latch ramp_code into data and move to OUTPUT.
  - If cmp=0 while ramp_code==MAX: latch MAX (saturate) and move to OUTPUT. ramp_code never wraps.
  - On leaving CONVERT, ramp_code returns to 0 and convert to 0.
- OUTPUT:
  - data_valid=1 and data held stable until a cycle with data_valid&&data_ready.
  - The state then returns to IDLE and data_valid drops on the next cycle. data retains its last value.
- Latency: with crossing code k, data_valid rises ERASE_CYCLES + 2*EXPOSE_PULSES + k + 1 cycles after the first cycle with erase=1.
- erase, expose and convert are mutually exclusive. At most one is high in any cycle.

Optional Feature:
Macro: PIXEL_CDS_EN
- Defined: correlated double sampling.
  - Sequence is ERASE -> CONV_RST -> EXPOSE -> CONVERT -> OUTPUT.
  - CONV_RST runs the same ramp procedure as CONVERT with erase=0 and expose=0, storing the reset code r.
  - CONVERT produces the signal code s.
  - data = s-r if s>=r, else 0.
  - Latency grows by r+1 cycles.
- Not defined: CONV_RST state and reset-code register are absent; data = s.

Test Plan:
1. Params ERASE_CYCLES=4, EXPOSE_PULSES=10. Pulse start; cmp rises when ramp_code==100; data_ready=1 -> erase high 4 cycles, expose high 20 cycles with 10 vbn1 rising edges, data=100, data_valid rises 4+20+101=125 cycles after erase first high.
2. cmp held 0 throughout -> ramp_code reaches 255 without wrap, data=255; cmp held 1 -> data=0 after a single CONVERT cycle.
3. data_ready=0 for 20 cycles in OUTPUT, start pulsed meanwhile -> data_valid stays 1, data unchanged, busy=1, start ignored; data_ready=1 -> data_valid=0 next cycle, IDLE.
4. reset asserted on the 7th EXPOSE cycle -> next cycle expose, vbn1 and busy are 0, no data_valid ever; a fresh start afterwards completes normally.
5. PIXEL_CDS_EN: reset crossing 10, signal crossing 100 -> data=90. Reset crossing 50, signal crossing 30 -> data=0. Confirm erase=0 during CONV_RST.
